// File: rtl/conv_window_gen3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// slave = the window generator, master = pixel source plus window consumer.
interface conv_window_gen3x3_if #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [9*DATA_W-1:0]   win_data;
  logic [ROW_W-1:0]      win_row;
  logic [COL_W-1:0]      win_col;
  logic                  frame_done;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col, frame_done
  );
endinterface

// File: rtl/conv_window_gen3x3.sv
// Raster pixel stream -> valid-mode 3x3 windows using two line buffers and a 3x3 shift array.
// The shift array doubles as the single output register; it only moves on an accepted pixel.
module conv_window_gen3x3 #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_clr,
  conv_window_gen3x3_if.slave   bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] sh  [3][3];
  logic              win_valid_q;
  logic [ROW_W-1:0]  win_row_q;
  logic [COL_W-1:0]  win_col_q;

  logic accept, emit, row_end, frame_end, win_take;

  assign bus.in_ready = !win_valid_q || bus.win_ready;
  assign accept       = bus.in_valid && bus.in_ready && !frame_clr;
  assign row_end      = (col == COL_LAST);
  assign frame_end    = row_end && (row == ROW_LAST);
  assign emit         = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign win_take     = win_valid_q && bus.win_ready && !frame_clr;

  // FSM only tracks where the frame's last window is, so frame_done can fire on its handshake.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    state_nxt      = state;
    bus.frame_done = 1'b0;
    case (state)
      FILL:    if (accept && row_end && row == ROW_W'(1)) state_nxt = RUN;
      RUN:     if (accept && frame_end) state_nxt = DRAIN;
      DRAIN: begin
        if (win_take) begin
          state_nxt      = FILL;
          bus.frame_done = 1'b1;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (frame_clr) state_nxt = FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values of its neighbours.
      state <= state_nxt;
      if (frame_clr) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (row_end) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // NOTE: line-buffer RAM is deliberately not reset so it maps onto RAM; rows 0 and 1 of a
  // frame always rewrite both buffers before any window reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          sh[i][j] <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          sh[i][0] <= sh[i][1];
          sh[i][1] <= sh[i][2];
        end
        sh[0][2] <= lb1[col];
        sh[1][2] <= lb0[col];
        sh[2][2] <= bus.in_data;
      end
      if (frame_clr) begin
        win_valid_q <= 1'b0;
      end else if (emit) begin
        win_valid_q <= 1'b1;
        win_row_q   <= row - ROW_W'(2);
        win_col_q   <= col - COL_W'(2);
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign bus.win_data[(gi*3+gj)*DATA_W +: DATA_W] = sh[gi][gj];
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
endmodule
